// File: rtl/apb_mem_window.sv
// apb_mem_window
//   APB completer that exposes a wide on-chip memory (DATA_W bits x DEPTH
//   entries) as WORDS = DATA_W/32 consecutive 32-bit words per entry,
//   starting at BASE_ADDR. Each entry occupies 2**clog2(WORDS) word slots.
//   - Writes to the lower words of an entry land in staging registers.
//   - A write to the top word commits the whole entry, the staged words plus
//     pwdata, in one memory write.
//   - A read of word 0 always fetches the entry into a snapshot register.
//   - Reads of higher words of the snapshotted entry are served from the
//     snapshot, so software sees an atomic multi-word read.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   psel, penable, pwrite, paddr, pwdata
//                  APB request
//   prdata, pready, pslverr
//                  APB response
//   mem_req, mem_we, mem_addr, mem_wdata
//                  memory request, held until granted
//   mem_gnt        memory grant
//   mem_rdata      memory read data, RD_LAT cycles after a granted read
//   dbg_state      current FSM state (0 IDLE, 1 REQ, 2 RDWAIT, 3 RESP)
//
// Handshakes
//   APB: a transfer is active on cycles with psel & penable. It completes on
//   the cycle where pready=1; prdata and pslverr are valid only on that cycle.
//   Memory: mem_req is a valid that is held high, with mem_we, mem_addr and
//   mem_wdata stable, until a cycle where mem_req & mem_gnt. The access is
//   accepted on that cycle. For a granted read, mem_rdata is sampled exactly
//   RD_LAT cycles later.
module apb_mem_window #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DATA_W      = 64,
    parameter int          DEPTH       = 10,
    parameter int          RD_LAT      = 1,
    parameter int          GNT_TIMEOUT = 0,
    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam int WORDS = DATA_W / 32;
    // Width of the word field in the address; zero when an entry is one word.
    localparam int WSB   = (WORDS > 1) ? $clog2(WORDS) : 0;
    localparam int WS    = (WSB > 0) ? WSB : 1;
    localparam int TO_W  = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RDWAIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [31:0]       stage [WORDS];
    logic [DATA_W-1:0] snap;
    logic [AW-1:0]     snap_idx;
    logic              snap_vld;
    logic [WS-1:0]     word_q;
    logic [2:0]        lat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              pready_q;
    logic              pslverr_q;
    logic [31:0]       prdata_q;

    // Address decode
    logic [31:0]       off;
    logic [31:0]       entry_full;
    logic [WS-1:0]     word;
    logic [AW-1:0]     entry;
    logic              dec_err;
    logic              is_last;
    logic              snap_hit;
    logic [31:0]       snap_word;
    logic [DATA_W-1:0] commit_data;

    assign off        = paddr - BASE_ADDR;
    assign entry_full = off >> (2 + WSB);
    assign word       = (WSB > 0) ? off[2 +: WS] : '0;
    assign entry      = entry_full[AW-1:0];
    assign dec_err    = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) ||
                        (entry_full >= 32'(DEPTH)) || (32'(word) >= 32'(WORDS));
    assign is_last    = (32'(word) == 32'(WORDS - 1));
    assign snap_hit   = snap_vld && (snap_idx == entry) && (word != '0);
    assign snap_word  = snap[32'(word) * 32 +: 32];

    // Full entry image for a commit: the staged lower words plus pwdata on top.
    always_comb begin
        commit_data = '0;
        for (int j = 0; j < WORDS - 1; j++) begin
            commit_data[j*32 +: 32] = stage[j];
        end
        commit_data[(WORDS-1)*32 +: 32] = pwdata;
    end

    // First access cycle in IDLE. Errors, staged writes and snapshot hits
    // complete combinationally on this cycle.
    logic access, idle_acc, err_now, zw_write, zw_read;

    assign access   = psel & penable;
    assign idle_acc = (state == S_IDLE) && access;
    assign err_now  = idle_acc && dec_err;
    assign zw_write = idle_acc && !dec_err && pwrite && !is_last;
    assign zw_read  = idle_acc && !dec_err && !pwrite && snap_hit;

    assign pready    = pready_q | err_now | zw_write | zw_read;
    assign pslverr   = pslverr_q | err_now;
    assign dbg_state = state;

    always_comb begin
        prdata = prdata_q;
        if (err_now) begin
            prdata = 32'hBADD_C0DE;
        end else if (zw_read) begin
            prdata = snap_word;
        end else if (zw_write) begin
            prdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            snap      <= '0;
            snap_idx  <= '0;
            snap_vld  <= 1'b0;
            word_q    <= '0;
            lat_cnt   <= '0;
            to_cnt    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < WORDS; i++) begin
                stage[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && !dec_err) begin
                        if (pwrite) begin
                            if (!is_last) begin
                                stage[word] <= pwdata;
                            end else begin
                                mem_wdata <= commit_data;
                                mem_we    <= 1'b1;
                                mem_addr  <= entry;
                                mem_req   <= 1'b1;
                                to_cnt    <= '0;
                                state     <= S_REQ;
                            end
                        end else if (!snap_hit) begin
                            mem_we   <= 1'b0;
                            mem_addr <= entry;
                            mem_req  <= 1'b1;
                            word_q   <= word;
                            to_cnt   <= '0;
                            state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A grant takes priority over a timeout that expires on
                    // the same cycle.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            if (snap_idx == mem_addr) begin
                                snap_vld <= 1'b0;
                            end
                            pready_q <= 1'b1;
                            prdata_q <= '0;
                            state    <= S_RESP;
                        end else begin
                            lat_cnt <= 3'd1;
                            state   <= S_RDWAIT;
                        end
                    end else if ((GNT_TIMEOUT > 0) &&
                                 (to_cnt == TO_W'(GNT_TIMEOUT - 1))) begin
                        // Abandon the access. Drop the pending write image so
                        // the commit is not left behind on the memory port.
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                        state     <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RDWAIT: begin
                    if (lat_cnt == 3'(RD_LAT)) begin
                        snap     <= mem_rdata;
                        snap_idx <= mem_addr;
                        snap_vld <= 1'b1;
                        prdata_q <= mem_rdata[32'(word_q) * 32 +: 32];
                        pready_q <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
